// File: rtl/playlist_mcu_pkg.sv
// Shared encodings for the playlist control unit: FSM states, playback modes
// and the shuffle LFSR seed.
package playlist_mcu_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'b00,
        ST_PLAY   = 2'b01,
        ST_SWITCH = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MODE_SEQ     = 2'b00,
        MODE_STOP    = 2'b01,
        MODE_REPEAT  = 2'b10,
        MODE_SHUFFLE = 2'b11
    } mode_t;

    localparam logic [7:0] LFSR_SEED = 8'h01;

endpackage

// File: rtl/playlist_mcu_shuffle_lfsr.sv
// Free-running 8-bit LFSR that proposes a shuffle target which is always a
// legal index and never equal to the song currently selected.
module shuffle_lfsr
    import playlist_mcu_pkg::*;
#(
    parameter int NUM_SONGS = 4,
    parameter int SONG_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SONG_W-1:0] cur_song,
    output logic [SONG_W-1:0] pick
);

    localparam logic [SONG_W:0]   L_NUM  = (SONG_W+1)'(NUM_SONGS);
    localparam logic [SONG_W-1:0] L_LAST = SONG_W'(NUM_SONGS - 1);

    logic [7:0]        r_lfsr;
    logic              w_fb;
    logic [SONG_W:0]   w_raw;
    logic [SONG_W-1:0] w_cand;

    // Taps x^8 + x^6 + x^5 + x^4 + 1; a nonzero seed keeps it off the all-zero lock-up state.
    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    always_comb begin
        w_raw  = {1'b0, r_lfsr[SONG_W-1:0]};
        w_cand = r_lfsr[SONG_W-1:0];
        // Minimal SONG_W means one subtraction always lands in range.
        if (w_raw >= L_NUM) begin
            w_cand = SONG_W'(w_raw - L_NUM);
        end
        pick = w_cand;
        if (w_cand == cur_song) begin
            pick = (cur_song == L_LAST) ? '0 : cur_song + SONG_W'(1);
        end
    end

endmodule

// File: rtl/playlist_mcu.sv
// Music-player control FSM: play/pause, next/prev navigation, end-of-song
// handling for four playback modes, with a one-cycle SWITCH restart pulse.
module playlist_mcu
    import playlist_mcu_pkg::*;
#(
    parameter int NUM_SONGS = 4,
    parameter int SONG_W    = 2,
    parameter bit AUTO_PLAY = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              prev_button,
    input  logic [1:0]        mode,
    input  logic              song_done,
    output logic              play,
    output logic              reset_player,
    output logic [SONG_W-1:0] song,
    output logic              playlist_done
);

    localparam logic [SONG_W-1:0] L_LAST = SONG_W'(NUM_SONGS - 1);

    function automatic logic [SONG_W-1:0] f_inc(input logic [SONG_W-1:0] s);
        return (s == L_LAST) ? '0 : s + SONG_W'(1);
    endfunction

    function automatic logic [SONG_W-1:0] f_dec(input logic [SONG_W-1:0] s);
        return (s == '0) ? L_LAST : s - SONG_W'(1);
    endfunction

    state_t            r_state, w_state;
    logic [SONG_W-1:0] r_song, w_song;
    logic              r_resume, w_resume;
    logic              r_reset_player, w_reset_player;
    logic              r_playlist_done, w_playlist_done;
    logic [SONG_W-1:0] w_pick;
    mode_t             w_mode;

    shuffle_lfsr #(
        .NUM_SONGS (NUM_SONGS),
        .SONG_W    (SONG_W)
    ) u_shuffle (
        .clk      (clk),
        .reset    (reset),
        .cur_song (r_song),
        .pick     (w_pick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_PAUSE;
            r_song          <= '0;
            r_resume        <= 1'b0;
            r_reset_player  <= 1'b0;
            r_playlist_done <= 1'b0;
        end else begin
            r_state         <= w_state;
            r_song          <= w_song;
            r_resume        <= w_resume;
            r_reset_player  <= w_reset_player;
            r_playlist_done <= w_playlist_done;
        end
    end

    always_comb begin
        w_state         = r_state;
        w_song          = r_song;
        w_resume        = r_resume;
        w_reset_player  = 1'b0;
        w_playlist_done = 1'b0;
        w_mode          = mode_t'(mode);

        case (r_state)
            ST_SWITCH: begin
                w_state = r_resume ? ST_PLAY : ST_PAUSE;
            end
            ST_PAUSE, ST_PLAY: begin
                // Priority chain; anything below the winning event is dropped.
                if (next_button) begin
                    w_song         = (w_mode == MODE_SHUFFLE) ? w_pick : f_inc(r_song);
                    w_state        = ST_SWITCH;
                    w_resume       = (r_state == ST_PLAY);
                    w_reset_player = 1'b1;
                end else if (prev_button) begin
                    w_song         = f_dec(r_song);
                    w_state        = ST_SWITCH;
                    w_resume       = (r_state == ST_PLAY);
                    w_reset_player = 1'b1;
                end else if (song_done && (r_state == ST_PLAY)) begin
                    w_state        = ST_SWITCH;
                    w_reset_player = 1'b1;
                    case (w_mode)
                        MODE_SEQ: begin
                            w_song   = f_inc(r_song);
                            w_resume = AUTO_PLAY;
                        end
                        MODE_STOP: begin
                            if (r_song == L_LAST) begin
                                w_song          = '0;
                                w_resume        = 1'b0;
                                w_playlist_done = 1'b1;
                            end else begin
                                w_song   = f_inc(r_song);
                                w_resume = AUTO_PLAY;
                            end
                        end
                        MODE_REPEAT: begin
                            w_resume = 1'b1;
                        end
                        MODE_SHUFFLE: begin
                            w_song   = w_pick;
                            w_resume = AUTO_PLAY;
                        end
                    endcase
                end else if (play_button) begin
                    w_state = (r_state == ST_PLAY) ? ST_PAUSE : ST_PLAY;
                end
            end
            default: begin
                w_state = ST_PAUSE;
            end
        endcase
    end

    assign play          = (r_state == ST_PLAY);
    assign reset_player  = r_reset_player;
    assign song          = r_song;
    assign playlist_done = r_playlist_done;

endmodule
